// File: rtl/pipe_mem_access_ctrl.sv
// pipe_mem_access_ctrl
//
// Sequences host accesses into the pipeline instruction and data memories.
// It takes one command at a time, stalls the core, waits until in-flight
// instructions have drained, performs a single read or write on the selected
// memory, then returns a response and releases the stall.
//
// Ports
//   clk, reset                 system clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_target                 0 = imem, 1 = dmem
//   cmd_wr                     1 = write, 0 = read
//   cmd_addr, cmd_wdata        word address and write data
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_err          read data (0 for writes/errors), address-range error
//   ext_halt                   software halt request; stalls the core while high
//   core_stall                 registered stall for pipeline registers and PC
//   imem_* / dmem_*            controller-owned memory port (en drives the address mux)

module pipe_mem_access_ctrl #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_target,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,

  input  logic              ext_halt,
  output logic              core_stall,

  output logic              imem_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,

  output logic              dmem_en,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  // Stall counter only needs to reach DRAIN_CYCLES; keep at least one bit.
  localparam int unsigned CntW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0] DrainMax = CntW'(DRAIN_CYCLES);
  localparam logic [1:0]      LatLast  = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StAccess,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              core_stall_q, core_stall_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic accept;
  logic addr_bad;
  logic drained;
  logic port_own;
  logic access_wr;

  // cmd_ready_q is only ever set when the next state is idle, so it also
  // implies the controller is idle.
  assign accept   = cmd_valid & cmd_ready_q;
  assign addr_bad = (32'(cmd_addr) >= DEPTH);
  assign drained  = (stall_cnt_q >= DrainMax);

  // Next-state and command/response register updates.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    lat_cnt_d  = lat_cnt_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          tgt_d      = cmd_target;
          wr_d       = cmd_wr;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          rsp_data_d = '0;
          rsp_err_d  = addr_bad;
          lat_cnt_d  = '0;
          if (addr_bad) begin
            // Out-of-range: answer straight away, never touch a memory.
            state_d = StResp;
          end else if (drained) begin
            // ext_halt already kept the core stalled long enough.
            state_d = StAccess;
          end else begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (drained) begin
          state_d = StAccess;
        end
      end

      StAccess: begin
        lat_cnt_d = '0;
        if (wr_q) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (lat_cnt_q == LatLast) begin
          rsp_data_d = tgt_q ? dmem_rdata : imem_rdata;
          state_d    = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Stall and ready are registered off the next state so they change
  // together with the state register.
  always_comb begin
    core_stall_d = ext_halt | (state_d != StIdle);
    cmd_ready_d  = (state_d == StIdle);
    if (!core_stall_d) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q >= DrainMax) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      tgt_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      stall_cnt_q  <= '0;
      lat_cnt_q    <= '0;
      core_stall_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      stall_cnt_q  <= stall_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      core_stall_q <= core_stall_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  // Port ownership covers the access cycle and the read-latency wait; the
  // write strobe is confined to the single access cycle.
  assign port_own  = (state_q == StAccess) | (state_q == StWait);
  assign access_wr = (state_q == StAccess) & wr_q;

  always_comb begin
    imem_en    = port_own & ~tgt_q;
    imem_we    = access_wr & ~tgt_q;
    imem_addr  = imem_en ? addr_q : '0;
    imem_wdata = imem_en ? wdata_q : '0;

    dmem_en    = port_own & tgt_q;
    dmem_we    = access_wr & tgt_q;
    dmem_addr  = dmem_en ? addr_q : '0;
    dmem_wdata = dmem_en ? wdata_q : '0;
  end

  assign cmd_ready  = cmd_ready_q;
  assign core_stall = core_stall_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: doc/pipe_mem_access_ctrl.md
Name: pipe_mem_access_ctrl

Overview:
- Sequences host (register-interface) accesses into the pipeline's instruction and data memories.
- Accepts one command at a time. Stalls the core and waits for in-flight instructions to drain, then performs a single read or write on the selected memory. Returns a response and releases the stall.
- Replaces per-register interact/write enables with a single command/response handshake.
- Sits between the generic register block and the pipeline datapath's memory muxes.

Parameters:
- ADDR_W, 9, word address width of each memory.
- DEPTH, 512, number of valid words per memory; addr >= DEPTH is an error.
- DRAIN_CYCLES, 4, cycles the core must be stalled before a memory is touched.
- RD_LAT, 1, memory read latency in cycles (1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_target  in  1  0 = imem, 1 = dmem
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read data; 0 for writes and errors
- rsp_err  out  1  address out of range
- ext_halt  in  1  software halt request; core is stalled while high
- core_stall  out  1  stall/enable-gate for all pipeline registers and PC
- imem_en  out  1  imem port owned by controller (drives the address mux)
- imem_we  out  1  imem write strobe
- imem_addr  out  ADDR_W  imem address
- imem_wdata  out  32  imem write data
- imem_rdata  in  32  imem read data
- dmem_en  out  1  dmem port owned by controller
- dmem_we  out  1  dmem write strobe
- dmem_addr  out  ADDR_W  dmem address
- dmem_wdata  out  32  dmem write data
- dmem_rdata  in  32  dmem read data

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, stall_cnt = 0.
  - All outputs 0, except cmd_ready = 1 once reset deasserts.
  - Command registers are cleared.
- States: IDLE, DRAIN, ACCESS, WAIT, RESP.
- core_stall = ext_halt | (state != IDLE). It is a registered output, asserted the cycle after acceptance.
- stall_cnt counts consecutive cycles with core_stall = 1, saturating at DRAIN_CYCLES. It clears whenever core_stall = 0.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch target/wr/addr/wdata.
  - If addr >= DEPTH: go to RESP with rsp_err = 1 and rsp_data = 0. No memory strobe. core_stall is still asserted for the RESP cycles.
  - Otherwise, if stall_cnt >= DRAIN_CYCLES (ext_halt already held long enough): go to ACCESS.
  - Otherwise: go to DRAIN.
- DRAIN: remain until stall_cnt reaches DRAIN_CYCLES, then go to ACCESS. From ext_halt = 0, at least DRAIN_CYCLES cycles elapse between acceptance and the first en.
- ACCESS (exactly 1 cycle):
  - Assert the selected *_en; *_we = cmd_wr; drive addr/wdata.
  - Write: go to RESP with rsp_data = 0.
  - Read: go to WAIT.
- WAIT:
  - *_en stays asserted and addr is held, with we = 0.
  - Counts RD_LAT cycles, then captures the selected *_rdata into rsp_data and goes to RESP.
  - RD_LAT = 1 means capture on the cycle after ACCESS.
- RESP:
  - rsp_valid = 1; data and err are stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid drops and cmd_ready rises the next cycle.
  - A new command cannot be accepted in the same cycle as the response handshake.
- Memory ports:
  - Only the targeted memory's en/we toggle; the other stays 0.
  - we is high for exactly one cycle per write.
  - en is never asserted while core_stall = 0.
- ext_halt:
  - Deassertion mid-command does not release core_stall until the controller returns to IDLE.
  - Assertion in IDLE stalls the core without consuming a command.
- Reset mid-operation:
  - Aborts immediately; outputs return to reset values asynchronously.
  - No partial write is issued after reset deasserts.
  - Any pending response is lost.
- cmd_valid while not ready is ignored. The host holds it, per valid/ready convention.
- Minimum latency, acceptance to rsp_valid:
  - Read from ext_halt = 0: DRAIN_CYCLES + 1 + RD_LAT + 1.
  - Write from ext_halt = 0: DRAIN_CYCLES + 2.

Test Plan:
- imem write, ext_halt = 0, addr = 9'h010, wdata = 32'h00A00093:
  - core_stall rises the cycle after acceptance.
  - imem_we is high for exactly one cycle, 4 cycles later.
  - rsp_valid with rsp_data = 0 and err = 0; core_stall drops after rsp_ready.
- dmem read back after a prior write of 32'hCAFEF00D to addr 5, RD_LAT = 1:
  - rsp_data = 32'hCAFEF00D.
  - rsp_valid appears 7 cycles after acceptance.
  - dmem_we stays 0 throughout.
- ext_halt held 10 cycles, then imem read:
  - DRAIN is skipped; imem_en is asserted the cycle after acceptance.
  - core_stall remains 1 after the response while ext_halt is still high.
- cmd_addr = 9'h1FF with DEPTH = 256:
  - rsp_err = 1 and rsp_data = 0.
  - No en/we strobe on either memory.
- rsp_ready held low 5 cycles:
  - rsp_valid and rsp_data are stable; cmd_ready = 0; a second cmd_valid is not accepted.
  - Accepted only 1 cycle after the handshake.
- Reset asserted during DRAIN of a dmem write:
  - core_stall = 0 immediately and cmd_ready = 1 after release.
  - dmem_we is never pulsed, and the addressed word is unchanged on readback.
